// File: rtl/race_controller.sv
// race_controller -- two-player race sequencer.
//
// Walks a race through IDLE -> COUNTDOWN (light signal) -> RACE -> FINISHED.
// It keeps a millisecond race time per player, latches false starts, picks
// the winner, flags players that time out (DNF) and pulses restart whenever
// the datapath is cleared (back to menu, or abort when start_game drops).
//
// Ports:
//   clk           system clock, all state on the rising edge
//   reset         asynchronous active-low reset
//   tick_1khz     single-cycle 1 ms time-base enable
//   start_game    menu level, high while the player wants to race
//   back_tick     single-cycle "back to menu" request (used only in FINISHED)
//   key_p1/p2     accelerator key levels
//   p1/p2_position unsigned player positions
//   state         00 IDLE, 01 COUNTDOWN, 10 RACE, 11 FINISHED
//   light_stage   elapsed countdown seconds
//   enable_p1/p2  game_controller enables, high while a player is still racing
//   time_p1/p2    {seconds[21:10], milliseconds[9:0]}
//   false_start_p1/p2, dnf_p1/p2  latched per-player flags
//   winner        00 none, 01 P1, 10 P2, 11 tie
//   end_game      high throughout FINISHED
//   restart       one-cycle pulse issued together with the datapath clear
module race_controller #(
    parameter int unsigned FINISH_LINE_POS = 2000,
    parameter int unsigned COUNTDOWN_S     = 5,
    parameter int unsigned TICKS_PER_S     = 1000,
    parameter int unsigned MAX_RACE_S      = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1khz,
    input  logic        start_game,
    input  logic        back_tick,
    input  logic        key_p1,
    input  logic        key_p2,
    input  logic [31:0] p1_position,
    input  logic [31:0] p2_position,
    output logic [1:0]  state,
    output logic [2:0]  light_stage,
    output logic        enable_p1,
    output logic        enable_p2,
    output logic [21:0] time_p1,
    output logic [21:0] time_p2,
    output logic        false_start_p1,
    output logic        false_start_p2,
    output logic        dnf_p1,
    output logic        dnf_p2,
    output logic [1:0]  winner,
    output logic        end_game,
    output logic        restart
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_COUNTDOWN = 2'b01,
        S_RACE      = 2'b10,
        S_FINISHED  = 2'b11
    } state_t;

    localparam int unsigned PRE_W     = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
    localparam int unsigned SEC_W     = $clog2(MAX_RACE_S + 1);
    localparam logic [2:0]  LIGHT_END = 3'(COUNTDOWN_S);
    localparam logic [21:0] ONE_S     = {12'd1, 10'd0};
    localparam logic [21:0] TIME_MAX  = {12'd4095, 10'd999};

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;      // ticks within the current second
    logic [SEC_W-1:0]   sec_q, sec_d;      // whole seconds spent in RACE
    logic               fin1_q, fin1_d;    // player has crossed the line
    logic               fin2_q, fin2_d;
    logic [2:0]         light_d;
    logic [21:0]        t1_d, t2_d;
    logic               fs1_d, fs2_d, dnf1_d, dnf2_d;
    logic [1:0]         win_d;
    logic               en1_d, en2_d, end_d, restart_d;
    logic               clear;
    logic               over_p1, over_p2, sec_edge, timeout;

    assign over_p1  = p1_position >= 32'(FINISH_LINE_POS);
    assign over_p2  = p2_position >= 32'(FINISH_LINE_POS);
    assign sec_edge = tick_1khz && (pre_q == PRE_W'(TICKS_PER_S - 1));
    assign timeout  = sec_edge && (sec_q == SEC_W'(MAX_RACE_S - 1));
    assign state    = state_q;

    // 1 ms step of {s, ms}: ms 999 carries into seconds, 4095.999 sticks.
    function automatic logic [21:0] time_inc(input logic [21:0] t);
        if (t == TIME_MAX)
            return t;
        else if (t[9:0] == 10'd999)
            return {t[21:10] + 12'd1, 10'd0};
        else
            return {t[21:10], t[9:0] + 10'd1};
    endfunction

    always_comb begin
        // NOTE: every value written here gets a hold/default first so no
        // path leaves it unassigned, otherwise synthesis infers a latch.
        state_d   = state_q;
        light_d   = light_stage;
        pre_d     = pre_q;
        sec_d     = sec_q;
        fin1_d    = fin1_q;
        fin2_d    = fin2_q;
        t1_d      = time_p1;
        t2_d      = time_p2;
        fs1_d     = false_start_p1;
        fs2_d     = false_start_p2;
        dnf1_d    = dnf_p1;
        dnf2_d    = dnf_p2;
        win_d     = winner;
        restart_d = 1'b0;
        clear     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_game) begin
                    state_d = S_COUNTDOWN;
                    pre_d   = '0;
                    light_d = '0;
                end
            end

            S_COUNTDOWN: begin
                if (!start_game) begin
                    clear = 1'b1;
                end else begin
                    if (key_p1) fs1_d = 1'b1;
                    if (key_p2) fs2_d = 1'b1;
                    if (tick_1khz) begin
                        if (sec_edge) begin
                            pre_d   = '0;
                            light_d = light_stage + 3'd1;
                            if (light_d == LIGHT_END) begin
                                // A false start costs a 1 s penalty up front.
                                state_d = S_RACE;
                                sec_d   = '0;
                                t1_d    = fs1_d ? ONE_S : '0;
                                t2_d    = fs2_d ? ONE_S : '0;
                            end
                        end else begin
                            pre_d = pre_q + PRE_W'(1);
                        end
                    end
                end
            end

            S_RACE: begin
                if (!start_game) begin
                    clear = 1'b1;
                end else begin
                    if (tick_1khz) begin
                        if (sec_edge) begin
                            pre_d = '0;
                            sec_d = sec_q + SEC_W'(1);
                        end else begin
                            pre_d = pre_q + PRE_W'(1);
                        end
                    end
                    // Crossing the line freezes the time on the same edge.
                    fin1_d = fin1_q || over_p1;
                    fin2_d = fin2_q || over_p2;
                    if (tick_1khz && !fin1_d && !dnf_p1) t1_d = time_inc(time_p1);
                    if (tick_1khz && !fin2_d && !dnf_p2) t2_d = time_inc(time_p2);
                    if (winner == 2'b00)
                        win_d = {fin2_d, fin1_d};
                    if (timeout) begin
                        dnf1_d = !fin1_d;
                        dnf2_d = !fin2_d;
                    end
                    if ((fin1_d || dnf1_d) && (fin2_d || dnf2_d))
                        state_d = S_FINISHED;
                end
            end

            S_FINISHED: begin
                if (back_tick) clear = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            state_d   = S_IDLE;
            restart_d = 1'b1;
            light_d   = '0;
            pre_d     = '0;
            sec_d     = '0;
            fin1_d    = 1'b0;
            fin2_d    = 1'b0;
            t1_d      = '0;
            t2_d      = '0;
            fs1_d     = 1'b0;
            fs2_d     = 1'b0;
            dnf1_d    = 1'b0;
            dnf2_d    = 1'b0;
            win_d     = 2'b00;
        end

        en1_d = (state_d == S_RACE) && !fin1_d && !over_p1 && !dnf1_d;
        en2_d = (state_d == S_RACE) && !fin2_d && !over_p2 && !dnf2_d;
        end_d = (state_d == S_FINISHED);
    end

    // NOTE: the reset branch clears everything asynchronously, so a reset
    // mid-race shows IDLE and zero outputs without waiting for a clk edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            light_stage    <= '0;
            pre_q          <= '0;
            sec_q          <= '0;
            fin1_q         <= 1'b0;
            fin2_q         <= 1'b0;
            time_p1        <= '0;
            time_p2        <= '0;
            false_start_p1 <= 1'b0;
            false_start_p2 <= 1'b0;
            dnf_p1         <= 1'b0;
            dnf_p2         <= 1'b0;
            winner         <= 2'b00;
            enable_p1      <= 1'b0;
            enable_p2      <= 1'b0;
            end_game       <= 1'b0;
            restart        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            state_q        <= state_d;
            light_stage    <= light_d;
            pre_q          <= pre_d;
            sec_q          <= sec_d;
            fin1_q         <= fin1_d;
            fin2_q         <= fin2_d;
            time_p1        <= t1_d;
            time_p2        <= t2_d;
            false_start_p1 <= fs1_d;
            false_start_p2 <= fs2_d;
            dnf_p1         <= dnf1_d;
            dnf_p2         <= dnf2_d;
            winner         <= win_d;
            enable_p1      <= en1_d;
            enable_p2      <= en2_d;
            end_game       <= end_d;
            restart        <= restart_d;
        end
    end

endmodule

// File: tb/tb_race_controller.sv
// Testbench for race_controller: table-driven race phase plus hand-written
// sequences for countdown timing, timeout/DNF, abort, async reset and the
// millisecond carry / saturation corners.
module tb_race_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_1khz, start_game, back_tick, key_p1, key_p2;
    logic [31:0] p1_position, p2_position;
    logic [1:0]  state;
    logic [2:0]  light_stage;
    logic        enable_p1, enable_p2;
    logic [21:0] time_p1, time_p2;
    logic        false_start_p1, false_start_p2, dnf_p1, dnf_p2;
    logic [1:0]  winner;
    logic        end_game, restart;

    int total = 0;
    int bad   = 0;

    race_controller dut (
        .clk            (clk),
        .reset          (reset),
        .tick_1khz      (tick_1khz),
        .start_game     (start_game),
        .back_tick      (back_tick),
        .key_p1         (key_p1),
        .key_p2         (key_p2),
        .p1_position    (p1_position),
        .p2_position    (p2_position),
        .state          (state),
        .light_stage    (light_stage),
        .enable_p1      (enable_p1),
        .enable_p2      (enable_p2),
        .time_p1        (time_p1),
        .time_p2        (time_p2),
        .false_start_p1 (false_start_p1),
        .false_start_p2 (false_start_p2),
        .dnf_p1         (dnf_p1),
        .dnf_p2         (dnf_p2),
        .winner         (winner),
        .end_game       (end_game),
        .restart        (restart)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p1;
        logic [31:0] p2;
        int          n;     // ticking cycles to run after applying positions
        logic [1:0]  st;
        logic [21:0] t1;
        logic [21:0] t2;
        logic [1:0]  en;    // {enable_p1, enable_p2}
        logic [1:0]  win;
        logic        fin;
    } vec_t;

    vec_t tbl [4];

    function automatic logic [21:0] tm(input int s, input int ms);
        return {12'(s), 10'(ms)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges; inputs are driven and outputs sampled 1 ns later.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Race phase after a P1 false start: P1 starts at 1.000 s.
        tbl[0] = '{p1: 0,    p2: 0,    n: 3200, st: 2'b10, t1: tm(4, 200), t2: tm(3, 200), en: 2'b11, win: 2'b00, fin: 1'b0};
        tbl[1] = '{p1: 2000, p2: 0,    n: 300,  st: 2'b10, t1: tm(4, 200), t2: tm(3, 500), en: 2'b01, win: 2'b01, fin: 1'b0};
        tbl[2] = '{p1: 2000, p2: 2000, n: 1,    st: 2'b11, t1: tm(4, 200), t2: tm(3, 500), en: 2'b00, win: 2'b01, fin: 1'b1};
        tbl[3] = '{p1: 2000, p2: 2000, n: 3,    st: 2'b11, t1: tm(4, 200), t2: tm(3, 500), en: 2'b00, win: 2'b01, fin: 1'b1};

        reset = 1'b0; tick_1khz = 1'b0; start_game = 1'b0; back_tick = 1'b0;
        key_p1 = 1'b0; key_p2 = 1'b0; p1_position = '0; p2_position = '0;

        // ---------------- reset state ----------------
        cyc(2);
        check("rst_state", 32'(state), 0);
        check("rst_time_p1", 32'(time_p1), 0);
        check("rst_restart", 32'(restart), 0);
        reset = 1'b1;
        cyc(1);
        check("idle_wait", 32'(state), 0);

        // ---------------- countdown timing, no keys ----------------
        start_game = 1'b1;
        cyc(1);
        check("cd_entry_state", 32'(state), 1);
        check("cd_entry_light", 32'(light_stage), 0);
        tick_1khz = 1'b1;
        for (int s = 1; s <= 5; s++) begin
            cyc(999);
            check($sformatf("light_before_%0d", s), 32'(light_stage), 32'(s - 1));
            cyc(1);
            check($sformatf("light_at_%0d", s), 32'(light_stage), 32'(s));
            check($sformatf("state_at_%0d", s), 32'(state), (s == 5) ? 2 : 1);
        end
        check("race_en", 32'({enable_p1, enable_p2}), 3);
        check("race_t1_start", 32'(time_p1), 0);
        check("race_no_fs", 32'({false_start_p1, false_start_p2}), 0);

        // ---------------- ms carry, P1 finish, saturation, timeout ----------------
        cyc(999);                                   // 999 race ticks
        check("t1_999", 32'(time_p1), 32'(tm(0, 999)));
        cyc(1);                                     // 1000
        check("t1_carry", 32'(time_p1), 32'(tm(1, 0)));
        p1_position = 32'd2000;
        cyc(1);                                     // 1001
        check("p1_frozen", 32'(time_p1), 32'(tm(1, 0)));
        check("p2_runs", 32'(time_p2), 32'(tm(1, 1)));
        check("win_p1", 32'(winner), 1);
        check("en_after_p1", 32'({enable_p1, enable_p2}), 1);
        force dut.time_p2 = tm(4095, 999);
        cyc(1);                                     // 1002
        release dut.time_p2;
        cyc(1);                                     // 1003
        check("t2_saturate", 32'(time_p2), 32'(tm(4095, 999)));
        cyc(60000 - 1003 - 1);                      // 59999
        check("pre_timeout_state", 32'(state), 2);
        check("pre_timeout_dnf2", 32'(dnf_p2), 0);
        cyc(1);                                     // 60000 -> timeout
        check("timeout_state", 32'(state), 3);
        check("timeout_dnf", 32'({dnf_p1, dnf_p2}), 1);
        check("timeout_win", 32'(winner), 1);
        check("timeout_end", 32'(end_game), 1);
        check("timeout_en", 32'({enable_p1, enable_p2}), 0);

        tick_1khz = 1'b0; back_tick = 1'b1; start_game = 1'b0;
        cyc(1);
        back_tick = 1'b0;
        check("back_restart", 32'(restart), 1);
        check("back_state", 32'(state), 0);
        check("back_clear", 32'({time_p1, time_p2, winner, dnf_p1, dnf_p2, light_stage, end_game}), 0);
        cyc(1);
        check("restart_one_cycle", 32'(restart), 0);
        p1_position = '0;

        // ---------------- false start, table-driven race ----------------
        start_game = 1'b1;
        cyc(1);
        key_p1 = 1'b1;
        cyc(3);
        key_p1 = 1'b0;
        check("fs_flags", 32'({false_start_p1, false_start_p2}), 2);
        tick_1khz = 1'b1;
        cyc(5000);
        check("fs_race_state", 32'(state), 2);
        check("fs_t1_penalty", 32'(time_p1), 32'(tm(1, 0)));
        check("fs_t2_zero", 32'(time_p2), 0);
        tick_1khz = 1'b0; back_tick = 1'b1;
        cyc(1);
        back_tick = 1'b0;
        check("back_ignored_state", 32'(state), 2);
        check("back_ignored_restart", 32'(restart), 0);
        tick_1khz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p1_position = tbl[i].p1;
            p2_position = tbl[i].p2;
            cyc(tbl[i].n);
            check($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("v%0d_t1", i), 32'(time_p1), 32'(tbl[i].t1));
            check($sformatf("v%0d_t2", i), 32'(time_p2), 32'(tbl[i].t2));
            check($sformatf("v%0d_en", i), 32'({enable_p1, enable_p2}), 32'(tbl[i].en));
            check($sformatf("v%0d_win", i), 32'(winner), 32'(tbl[i].win));
            check($sformatf("v%0d_end", i), 32'(end_game), 32'(tbl[i].fin));
            check($sformatf("v%0d_fs", i), 32'({false_start_p1, false_start_p2}), 2);
        end
        tick_1khz = 1'b0; back_tick = 1'b1; start_game = 1'b0;
        cyc(1);
        back_tick = 1'b0;
        p1_position = '0; p2_position = '0;
        cyc(1);

        // ---------------- abort in countdown ----------------
        start_game = 1'b1;
        cyc(1);
        tick_1khz = 1'b1; key_p2 = 1'b1;
        cyc(10);
        key_p2 = 1'b0;
        check("abort_fs2_set", 32'(false_start_p2), 1);
        start_game = 1'b0; tick_1khz = 1'b0;
        cyc(1);
        check("abort_state", 32'(state), 0);
        check("abort_restart", 32'(restart), 1);
        check("abort_clear", 32'({false_start_p2, light_stage}), 0);
        cyc(1);

        // ---------------- async reset mid-race, then tie ----------------
        start_game = 1'b1; tick_1khz = 1'b1;
        cyc(1);
        cyc(5000);
        cyc(10);
        check("pre_reset_t1", 32'(time_p1), 32'(tm(0, 10)));
        #3 reset = 1'b0;
        #1;
        check("async_state", 32'(state), 0);
        check("async_outs", 32'({time_p1, time_p2, enable_p1, enable_p2, light_stage}), 0);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        check("rerun_cd", 32'(state), 1);
        check("rerun_light", 32'(light_stage), 0);
        cyc(5000);
        check("rerun_race", 32'(state), 2);
        cyc(250);
        p1_position = 32'd2000; p2_position = 32'd2000;
        cyc(1);
        check("tie_win", 32'(winner), 3);
        check("tie_t1", 32'(time_p1), 32'(tm(0, 250)));
        check("tie_t2", 32'(time_p2), 32'(tm(0, 250)));
        check("tie_state", 32'(state), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
